// File: rtl/store_queue.sv
// store_queue: decodes RISC-V SB/SH/SW, lane-replicates write data, builds the
// byte-write mask, and issues legal stores to memory in order from a small
// circular queue. Also flags loads that target a word still waiting in the queue.
module store_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wbe,
    input  logic [31:0] chk_addr,
    output logic        hazard,
    output logic        empty,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    count_s;
    logic [31:0]      addr_q_r  [DEPTH];
    logic [31:0]      wdata_q_r [DEPTH];
    logic [3:0]       wbe_q_r   [DEPTH];
    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             is_store_s;
    logic             bad_s;
    logic             push_s;
    logic             pop_s;
    logic             err_set_s;
    logic [3:0]       wbe_s;
    logic [31:0]      wdata_s;
    logic [DEPTH-1:0] match_s;
    logic             err_r;
    logic [31:0]      err_addr_r;
    logic             unused_s;

    // Instruction fields other than opcode/func3 and the low check-address bits are not needed.
    assign unused_s = ^{inst[31:15], inst[11:7], chk_addr[1:0]};

    // The pointer MSB distinguishes a full queue from an empty one with equal low bits.
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count_s    = wr_ptr_r - rd_ptr_r;
    assign in_ready   = !full_s && !rst;
    assign accept_s   = in_valid && in_ready;
    assign is_store_s = (inst[6:0] == 7'h23);
    assign push_s     = accept_s && is_store_s && !bad_s;
    assign err_set_s  = accept_s && is_store_s && bad_s;
    assign pop_s      = !empty_s && mem_ready;

    // Store-width decode: lane mask, replicated data and alignment/legality check.
    always_comb begin
        wbe_s   = 4'b0000;
        wdata_s = 32'h0000_0000;
        bad_s   = 1'b0;
        case (inst[14:12])
            3'b000: begin
                wbe_s   = 4'b0001 << addr[1:0];
                wdata_s = {4{data[7:0]}};
            end
            3'b001: begin
                wbe_s   = addr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{data[15:0]}};
                bad_s   = addr[0];
            end
            3'b010: begin
                wbe_s   = 4'b1111;
                wdata_s = data;
                bad_s   = (addr[1:0] != 2'b00);
            end
            default: begin
                bad_s   = 1'b1;
            end
        endcase
    end

    // Read/write pointers; power-of-two depth makes the natural wrap modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage; contents are only meaningful while the slot is occupied, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_q_r[wr_ptr_r[AW-1:0]]  <= {addr[31:2], 2'b00};
            wdata_q_r[wr_ptr_r[AW-1:0]] <= wdata_s;
            wbe_q_r[wr_ptr_r[AW-1:0]]   <= wbe_s;
        end
    end

    // Error pulse and sticky address of the most recent rejected store.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r      <= 1'b0;
            err_addr_r <= 32'h0000_0000;
        end else begin
            err_r <= err_set_s;
            if (err_set_s) begin
                err_addr_r <= addr;
            end else begin
                err_addr_r <= err_addr_r;
            end
        end
    end

    // Word-address match against every occupied slot (slot offset from head below count).
    always_comb begin
        logic [AW-1:0] off_v;
        off_v   = {AW{1'b0}};
        match_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_v      = AW'(i) - rd_ptr_r[AW-1:0];
            match_s[i] = ({1'b0, off_v} < count_s) &&
                         (addr_q_r[i][31:2] == chk_addr[31:2]);
        end
    end

    assign mem_valid = !empty_s;
    assign mem_addr  = addr_q_r[rd_ptr_r[AW-1:0]];
    assign mem_wdata = wdata_q_r[rd_ptr_r[AW-1:0]];
    assign mem_wbe   = wbe_q_r[rd_ptr_r[AW-1:0]];
    assign empty     = empty_s;
    assign hazard    = |match_s;
    assign err       = err_r;
    assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: a queue-of-records model predicts every
// output each cycle; directed scenarios add hand-computed literal expectations.
module tb_store_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data = 32'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;
    logic [31:0] chk_addr = 32'h0;
    logic        hazard;
    logic        empty;
    logic        err;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .addr(addr), .data(data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wbe(mem_wbe), .chk_addr(chk_addr),
        .hazard(hazard), .empty(empty), .err(err), .err_addr(err_addr)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    logic        merr = 1'b0;
    logic [31:0] merr_addr = 32'h0;
    logic [31:0] seen[$];
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [31:0] SW_I = 32'h0000_2023;
    localparam logic [31:0] SH_I = 32'h0000_1023;
    localparam logic [31:0] SB_I = 32'h0000_0023;
    localparam logic [31:0] LW_I = 32'h0000_2003;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Store semantics from first principles: size in bytes, natural alignment,
    // lane k of the write word carries data byte (k mod size).
    task automatic model_store(input logic [31:0] i, input logic [31:0] a,
                               input logic [31:0] d, output bit ok, output ent_t e);
        int sz;
        case (i[14:12])
            3'd0:    sz = 1;
            3'd1:    sz = 2;
            3'd2:    sz = 4;
            default: sz = 0;
        endcase
        e.a  = a & 32'hFFFF_FFFC;
        e.d  = 32'h0;
        e.be = 4'h0;
        ok   = 1'b0;
        if (sz != 0) begin
            ok   = ((a % sz) == 0);
            e.be = 4'(((1 << sz) - 1) << (a % 4));
            for (int k = 0; k < 4; k++) e.d[8*k +: 8] = d[8*(k % sz) +: 8];
        end
    endtask

    // One cycle: drive at negedge, compare everything against the model, advance the model.
    task automatic step(input bit r, input bit v, input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] d, input bit mr, input logic [31:0] ca, output bit acc);
        bit   exp_ir;
        bit   exp_hz;
        bit   ok;
        bit   nerr;
        ent_t e;
        @(negedge clk);
        rst = r; in_valid = v; inst = i; addr = a; data = d; mem_ready = mr; chk_addr = ca;
        #1;
        exp_ir = !r && (mq.size() < DEPTH);
        exp_hz = 1'b0;
        foreach (mq[k]) if (mq[k].a[31:2] == ca[31:2]) exp_hz = 1'b1;
        check("in_ready",  32'(in_ready),  32'(exp_ir));
        check("empty",     32'(empty),     32'(mq.size() == 0));
        check("mem_valid", 32'(mem_valid), 32'(mq.size() != 0));
        check("hazard",    32'(hazard),    32'(exp_hz));
        check("err",       32'(err),       32'(merr));
        check("err_addr",  err_addr,       merr_addr);
        if (mq.size() != 0) begin
            check("mem_addr",  mem_addr,       mq[0].a);
            check("mem_wdata", mem_wdata,      mq[0].d);
            check("mem_wbe",   32'(mem_wbe),   32'(mq[0].be));
        end
        if (mem_valid && mem_ready) seen.push_back(mem_addr);
        acc = v && exp_ir;
        if (r) begin
            mq.delete();
            merr = 1'b0;
            merr_addr = 32'h0;
        end else begin
            if (mq.size() != 0 && mr) void'(mq.pop_front());
            nerr = 1'b0;
            if (acc && i[6:0] == 7'h23) begin
                model_store(i, a, d, ok, e);
                if (ok) mq.push_back(e);
                else begin
                    nerr = 1'b1;
                    merr_addr = a;
                end
            end
            merr = nerr;
        end
    endtask

    task automatic idle(input bit mr, input logic [31:0] ca);
        bit acc;
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, mr, ca, acc);
    endtask

    initial begin
        bit          acc;
        int          tries;
        logic [31:0] ri;
        logic [31:0] ra;

        // Reset
        step(1'b1, 1'b1, SW_I, 32'h0, 32'h0, 1'b0, 32'h0, acc);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        idle(1'b0, 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_addr", err_addr, 32'h0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // SB to the top byte lane
        step(1'b0, 1'b1, SB_I, 32'h0000_1003, 32'hAABB_CCDD, 1'b1, 32'h0, acc);
        idle(1'b1, 32'h0);
        check("sb_valid", 32'(mem_valid), 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_wbe", 32'(mem_wbe), 32'h8);
        check("sb_wdata", mem_wdata, 32'hDDDD_DDDD);

        // SH upper half, then misaligned SH
        step(1'b0, 1'b1, SH_I, 32'h0000_2002, 32'h1234_ABCD, 1'b1, 32'h0, acc);
        idle(1'b1, 32'h0);
        check("sh_wbe", 32'(mem_wbe), 32'hC);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        step(1'b0, 1'b1, SH_I, 32'h0000_2001, 32'h1234_ABCD, 1'b1, 32'h0, acc);
        idle(1'b1, 32'h0);
        check("sh_mis_err", 32'(err), 32'd1);
        check("sh_mis_err_addr", err_addr, 32'h0000_2001);
        check("sh_mis_empty", 32'(empty), 32'd1);
        idle(1'b1, 32'h0);
        check("err_one_pulse", 32'(err), 32'd0);

        // Fill with memory stalled, then drain in order
        seen.delete();
        step(1'b0, 1'b1, SW_I, 32'h10, 32'h1, 1'b0, 32'h0, acc);
        step(1'b0, 1'b1, SW_I, 32'h14, 32'h2, 1'b0, 32'h0, acc);
        step(1'b0, 1'b1, SW_I, 32'h18, 32'h3, 1'b0, 32'h0, acc);
        check("full_stall", 32'(acc), 32'd0);
        step(1'b0, 1'b1, SW_I, 32'h18, 32'h3, 1'b1, 32'h0, acc);
        check("full_ready_pop", 32'(in_ready), 32'd0);
        idle(1'b0, 32'h0);
        check("ready_after_pop", 32'(in_ready), 32'd1);
        check("second_head", mem_addr, 32'h14);
        idle(1'b1, 32'h0);
        check("order_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("order_first", seen[0], 32'h10);
            check("order_second", seen[1], 32'h14);
        end

        // Hazard window
        step(1'b0, 1'b1, SW_I, 32'h40, 32'h5, 1'b0, 32'h43, acc);
        check("hz_new_not_counted", 32'(hazard), 32'd0);
        idle(1'b0, 32'h43);
        check("hz_same_word", 32'(hazard), 32'd1);
        idle(1'b0, 32'h44);
        check("hz_next_word", 32'(hazard), 32'd0);
        idle(1'b1, 32'h43);
        check("hz_popping_head", 32'(hazard), 32'd1);
        idle(1'b0, 32'h43);
        check("hz_after_pop", 32'(hazard), 32'd0);

        // Load opcode is swallowed silently
        step(1'b0, 1'b1, LW_I, 32'h0000_3001, 32'h0, 1'b0, 32'h0, acc);
        check("load_accepted", 32'(acc), 32'd1);
        idle(1'b0, 32'h0);
        check("load_empty", 32'(empty), 32'd1);
        check("load_no_err", 32'(err), 32'd0);

        // Fill, reset, then ten stores across pointer wrap
        step(1'b0, 1'b1, SW_I, 32'h80, 32'h7, 1'b0, 32'h0, acc);
        step(1'b0, 1'b1, SW_I, 32'h84, 32'h8, 1'b0, 32'h0, acc);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, acc);
        idle(1'b0, 32'h0);
        check("midrst_valid", 32'(mem_valid), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        seen.delete();
        for (int k = 0; k < 10; k++) begin
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 50) begin
                step(1'b0, 1'b1, SW_I, 32'h100 + 32'(4 * k), 32'(k), 1'($urandom), 32'h100, acc);
                tries++;
            end
            if (!acc) begin
                n_chk++;
                n_fail++;
                $display("FAIL wrap_accept_timeout: store %0d not accepted in 50 cycles", k);
            end
        end
        for (int k = 0; k < 6; k++) idle(1'b1, 32'h0);
        check("wrap_count", 32'(seen.size()), 32'd10);
        foreach (seen[k]) check("wrap_order", seen[k], 32'h100 + 32'(4 * k));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ri = $urandom;
            ri[6:0] = ($urandom_range(0, 9) < 8) ? 7'h23 : 7'($urandom);
            ri[14:12] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            ra = 32'h0000_0080 + 32'($urandom_range(0, 31));
            step(($urandom_range(0, 99) == 0), 1'($urandom), ri, ra, $urandom,
                 ($urandom_range(0, 2) != 0), 32'h0000_0080 + 32'($urandom_range(0, 31)), acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/store_queue.md
# store_queue

Store-side counterpart of the load extender. Takes a RISC-V store (SB/SH/SW) from the execute stage, checks alignment, replicates the data onto the correct byte lanes, and builds a 4-bit byte-write mask. Legal stores are held in a small in-order queue and issued to data memory over a valid/ready handshake. A word-address hazard check against the queued entries lets a later load stall instead of reading stale memory.

## Interface

Parameters:
- `DEPTH`, default 2: number of queue entries. Must be a power of two, 2 or larger.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a store candidate is presented.
- `in_ready` output 1: the block accepts a candidate this cycle.
- `inst` input 32: instruction word. Opcode is `inst[6:0]`, func3 is `inst[14:12]`.
- `addr` input 32: byte address (rs1 + immediate).
- `data` input 32: rs2 value.
- `mem_valid` output 1: the head entry is presented to memory.
- `mem_ready` input 1: memory takes the head entry.
- `mem_addr` output 32: word-aligned address, `{addr[31:2], 2'b00}`.
- `mem_wdata` output 32: lane-replicated write data.
- `mem_wbe` output 4: byte write enables. Bit i covers `mem_wdata[8i+7:8i]`.
- `chk_addr` input 32: address of the load being checked.
- `hazard` output 1: a queued store targets the same word as `chk_addr`.
- `empty` output 1: the queue holds no entries (used by fence and drain logic).
- `err` output 1: one-cycle pulse reporting a misaligned or illegal store.
- `err_addr` output 32: address of the most recent errored store.

## Operation

- Acceptance happens when `in_valid && in_ready`. `in_ready = !full && !rst`.
- Non-store opcode (`opc != 7'h23`): the candidate is accepted and discarded. No entry is created and `err` does not pulse.
- Store decode, with lane mapping little-endian and matching the load extender (byte at `addr[1:0]=3` sits in bits [31:24]):
  - SB (func3 000): wbe = `4'b0001 << addr[1:0]`. wdata = `{4{data[7:0]}}`.
  - SH (func3 001): wbe = `addr[1] ? 4'b1100 : 4'b0011`. wdata = `{2{data[15:0]}}`. Misaligned if `addr[0]`.
  - SW (func3 010): wbe = `4'b1111`. wdata = `data`. Misaligned if `addr[1:0] != 0`.
  - func3 011–111: illegal.
- Misaligned or illegal store: accepted but not enqueued. The cycle after acceptance, `err`=1 and `err_addr`=addr. `err_addr` holds its value until the next error.
- Queue:
  - Circular buffer with read/write pointers of width log2(DEPTH)+1, wrapping modulo 2·DEPTH.
  - full = MSBs differ and low bits equal. empty = pointers equal.
- Head entry drives `mem_addr`/`mem_wdata`/`mem_wbe` from registers. `mem_valid = !empty`.
- Pop on `mem_valid && mem_ready`.
- `hazard` is combinational: 1 if any occupied entry has `entry_addr[31:2] == chk_addr[31:2]`.
  - The head being popped this cycle still counts.
  - A candidate being accepted this cycle does not count.

## Timing

- Reset values: `mem_valid`=0, `empty`=1, `hazard`=0, `err`=0, `err_addr`=0, `in_ready`=0 during `rst` and 1 the first cycle after.
- Reset mid-operation discards all queued entries. Stores already handshaken to memory are unaffected.
- Latency: a store accepted in cycle N appears on `mem_valid` in cycle N+1 if the queue was empty.
- No input-to-output bypass.
- While `mem_valid && !mem_ready`, all `mem_*` outputs hold stable.
- Order is strictly FIFO. Memory never sees a reordered or duplicated store.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- When full, `in_ready`=0 even if `mem_ready`=1 that cycle. `in_ready` returns to 1 the next cycle.
- Pointer wrap past 2·DEPTH−1 is seamless. Full and empty detection stays correct across wrap.
- `err` never asserts two consecutive cycles unless two erroring stores are accepted back to back.

## Test plan

- SB, `addr=0x1003`, `data=0xAABBCCDD`, `mem_ready`=1 → next cycle `mem_valid`=1, `mem_addr=0x1000`, `mem_wbe=4'b1000`, `mem_wdata=0xDDDDDDDD`.
- SH at `0x2002`, `data=0x1234ABCD` → `mem_wbe=4'b1100`, `mem_wdata=0xABCDABCD`. SH at `0x2001` → `err` pulse, `err_addr=0x2001`, no memory transaction.
- With `mem_ready`=0, push SW 0x10, 0x14 (DEPTH=2) → `in_ready`=0 and the third store stalls. Raise `mem_ready` → memory sees 0x10 then 0x14 in order, and `in_ready` returns one cycle after the first pop.
- Queue holds SW to 0x40 → `chk_addr=0x43` gives `hazard`=1, `chk_addr=0x44` gives `hazard`=0. After the pop completes, `hazard`=0 for 0x43.
- Opcode `7'h03` (load) with `in_valid`=1 → accepted, `empty` stays 1, no `err`.
- Fill the queue, assert `rst` for one cycle → `mem_valid`=0, `empty`=1. Ten sequential stores then drain in order across pointer wrap.
